// File: rtl/mmio_pkg.sv
// mmio_pkg: register map, status bit indices and region tag shared by the MMIO controller.
package mmio_pkg;
  localparam logic [23:0] REGION    = 24'h800000;
  localparam logic [7:0]  STATUS    = 8'h00;
  localparam logic [7:0]  RX_DATA   = 8'h04;
  localparam logic [7:0]  TX_DATA   = 8'h08;
  localparam logic [7:0]  CYCLE_CTR = 8'h10;
  localparam logic [7:0]  INSTR_CTR = 8'h14;
  localparam logic [7:0]  CTR_RST   = 8'h18;
  localparam int ST_TX_EMPTY    = 0;
  localparam int ST_RX_NONEMPTY = 1;
endpackage

// File: rtl/mmio_rx_fifo.sv
// mmio_rx_fifo: RX byte buffer; circular FIFO with MMIO_RX_FIFO_EN, else a single holding register.
module mmio_rx_fifo #(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       full,
  output logic       empty
);
`ifdef MMIO_RX_FIFO_EN
  localparam int AW = $clog2(DEPTH);
  logic [AW:0] wp, rp;
  logic [7:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
    end
  end
  always_ff @(posedge clk)
    if (push) mem[wp[AW-1:0]] <= wdata;
  assign rdata = mem[rp[AW-1:0]];
  assign empty = wp == rp;
  assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
`else
  logic       held;
  logic [7:0] data;
  logic       unused_depth;
  assign unused_depth = ^DEPTH;
  always_ff @(posedge clk) begin
    if (rst) begin
      held <= 1'b0;
      data <= '0;
    end else if (push) begin
      held <= 1'b1;
      data <= wdata;
    end else if (pop) begin
      held <= 1'b0;
    end
  end
  assign rdata = data;
  assign full  = held;
  assign empty = !held;
`endif
endmodule

// File: rtl/mmio_ctrl.sv
// mmio_ctrl: MMIO decode, UART TX/RX sequencing, cycle/instret counters, 1-cycle load data.
// Optional MMIO_RX_FIFO_EN selects a RX_FIFO_DEPTH-entry RX FIFO instead of a single register.
module mmio_ctrl
  import mmio_pkg::*;
#(
  parameter int RX_FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic [31:0] resp_rdata,
  input  logic        instr_retire,
  output logic [7:0]  uart_tx_data_in,
  output logic        uart_tx_data_in_valid,
  input  logic        uart_tx_data_in_ready,
  input  logic [7:0]  uart_rx_data_out,
  input  logic        uart_rx_data_out_valid,
  output logic        uart_rx_data_out_ready
);
  logic        hit, ld, st, pop, push, rx_full, rx_empty, tx_full, tx_store, clr;
  logic [7:0]  off, rx_head;
  logic [31:0] cyc, instr, status, rd;
  logic        unused_wdata;
  assign unused_wdata = ^req_wdata[31:8];
  assign hit      = req_valid && req_addr[31:8] == REGION;
  assign off      = req_addr[7:0];
  assign ld       = hit && !req_we;
  assign st       = hit && req_we;
  assign pop      = ld && off == RX_DATA && !rx_empty;
  assign push     = uart_rx_data_out_valid && !rx_full;
  assign tx_store = st && off == TX_DATA && !tx_full;
  assign clr      = st && off == CTR_RST;
  assign uart_rx_data_out_ready = !rx_full;
  assign uart_tx_data_in_valid  = tx_full;
  mmio_rx_fifo #(.DEPTH(RX_FIFO_DEPTH)) u_rx (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .wdata(uart_rx_data_out),
    .rdata(rx_head), .full(rx_full), .empty(rx_empty)
  );
  always_comb begin
    status = '0;
    status[ST_TX_EMPTY]    = !tx_full;
    status[ST_RX_NONEMPTY] = !rx_empty;
    rd = !ld                ? '0 :
         off == STATUS    ? status :
         off == RX_DATA   ? {24'b0, rx_empty ? 8'h00 : rx_head} :
         off == CYCLE_CTR ? cyc :
         off == INSTR_CTR ? instr : '0;
  end
  // a full register ignores the store even if the handshake frees it this cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_full         <= 1'b0;
      uart_tx_data_in <= '0;
    end else if (tx_store) begin
      tx_full         <= 1'b1;
      uart_tx_data_in <= req_wdata[7:0];
    end else if (tx_full && uart_tx_data_in_ready) begin
      tx_full <= 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cyc   <= '0;
      instr <= '0;
    end else begin
      cyc   <= cyc + 1'b1;
      instr <= instr + {31'b0, instr_retire};
    end
  end
  always_ff @(posedge clk) begin
    if (rst) resp_rdata <= '0;
    else if (req_valid && !req_we) resp_rdata <= rd;
  end
endmodule

// File: tb/tb_mmio_ctrl.sv
// tb_mmio_ctrl: table-driven directed vectors plus counter, FIFO and reset sequences.
module tb_mmio_ctrl;
`ifdef MMIO_RX_FIFO_EN
  localparam bit F = 1'b1;
`else
  localparam bit F = 1'b0;
`endif
  logic        clk = 0, rst = 1;
  logic        req_valid = 0, req_we = 0, instr_retire = 0;
  logic [31:0] req_addr = 0, req_wdata = 0, resp_rdata;
  logic [7:0]  uart_tx_data_in, uart_rx_data_out = 0;
  logic        uart_tx_data_in_valid, uart_tx_data_in_ready = 0;
  logic        uart_rx_data_out_valid = 0, uart_rx_data_out_ready;
  int n_vec = 0, n_bad = 0;
  always #5 clk = ~clk;
  mmio_ctrl #(.RX_FIFO_DEPTH(8)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_rdata(resp_rdata), .instr_retire(instr_retire),
    .uart_tx_data_in(uart_tx_data_in), .uart_tx_data_in_valid(uart_tx_data_in_valid),
    .uart_tx_data_in_ready(uart_tx_data_in_ready), .uart_rx_data_out(uart_rx_data_out),
    .uart_rx_data_out_valid(uart_rx_data_out_valid), .uart_rx_data_out_ready(uart_rx_data_out_ready)
  );
  typedef struct {
    string       nm;
    logic        v, we;
    logic [31:0] a, wd;
    logic        txr, rxv;
    logic [7:0]  rxd;
    logic [31:0] resp;
    logic        txv;
    logic [7:0]  txd;
    logic        rxr;
  } vec_t;
  vec_t tv[$];
  function automatic vec_t mk(string nm, logic v, logic we, logic [31:0] a, logic [31:0] wd,
                              logic txr, logic rxv, logic [7:0] rxd,
                              logic [31:0] resp, logic txv, logic [7:0] txd, logic rxr);
    vec_t r;
    r.nm = nm; r.v = v; r.we = we; r.a = a; r.wd = wd; r.txr = txr; r.rxv = rxv; r.rxd = rxd;
    r.resp = resp; r.txv = txv; r.txd = txd; r.rxr = rxr;
    return r;
  endfunction
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic step(logic v, logic we, logic [31:0] a, logic [31:0] wd,
                      logic txr, logic rxv, logic [7:0] rxd, logic ret);
    req_valid = v; req_we = we; req_addr = a; req_wdata = wd;
    uart_tx_data_in_ready = txr; uart_rx_data_out_valid = rxv; uart_rx_data_out = rxd;
    instr_retire = ret;
    @(posedge clk);
    #1;
  endtask
  task automatic load(logic [31:0] a, logic rxv = 0, logic [7:0] rxd = 0);
    step(1, 0, a, 0, 0, rxv, rxd, 0);
  endtask
  task automatic idle(logic rxv = 0, logic [7:0] rxd = 0);
    step(0, 0, 0, 0, 0, rxv, rxd, 0);
  endtask
  task automatic do_reset;
    rst = 1;
    idle();
    idle();
    rst = 0;
  endtask
  initial begin
    tv.push_back(mk("status_rst",  1,0,32'h80000000,0,    0,0,0,     1,0,8'h00,1));
    tv.push_back(mk("tx_store",    1,1,32'h80000008,'h41, 0,0,0,     1,1,8'h41,1));
    tv.push_back(mk("tx_hold1",    0,0,0,0,               0,0,0,     1,1,8'h41,1));
    tv.push_back(mk("tx_drop",     1,1,32'h80000008,'h42, 0,0,0,     1,1,8'h41,1));
    tv.push_back(mk("st_txfull",   1,0,32'h80000000,0,    0,0,0,     0,1,8'h41,1));
    tv.push_back(mk("tx_hold2",    0,0,0,0,               0,0,0,     0,1,8'h41,1));
    tv.push_back(mk("tx_hs",       0,0,0,0,               1,0,0,     0,0,8'h41,1));
    tv.push_back(mk("st_txempty",  1,0,32'h80000000,0,    0,0,0,     1,0,8'h41,1));
    tv.push_back(mk("rx55",        0,0,0,0,               0,1,8'h55, 1,0,8'h41,F));
    tv.push_back(mk("rx66",        0,0,0,0,               0,1,8'h66, 1,0,8'h41,F));
    tv.push_back(mk("st_rx",       1,0,32'h80000000,0,    0,!F,8'h66,3,0,8'h41,F));
    tv.push_back(mk("pop55",       1,0,32'h80000004,0,    0,!F,8'h66,'h55,0,8'h41,1));
    tv.push_back(mk("rx66_late",   0,0,0,0,               0,!F,8'h66,'h55,0,8'h41,F));
    tv.push_back(mk("pop66",       1,0,32'h80000004,0,    0,0,0,     'h66,0,8'h41,1));
    tv.push_back(mk("pop_empty",   1,0,32'h80000004,0,    0,0,0,     0,0,8'h41,1));
    tv.push_back(mk("st_idle",     1,0,32'h80000000,0,    0,0,0,     1,0,8'h41,1));
    tv.push_back(mk("ld_gap",      1,0,32'h80000020,0,    0,0,0,     0,0,8'h41,1));
    tv.push_back(mk("st_idle2",    1,0,32'h80000000,0,    0,0,0,     1,0,8'h41,1));
    tv.push_back(mk("ld_outside",  1,0,32'h00001000,0,    0,0,0,     0,0,8'h41,1));
    tv.push_back(mk("st_idle3",    1,0,32'h80000000,0,    0,0,0,     1,0,8'h41,1));
    tv.push_back(mk("ld_wo",       1,0,32'h80000008,0,    0,0,0,     0,0,8'h41,1));
    tv.push_back(mk("st_outside",  1,1,32'h00001008,'h5A, 0,0,0,     0,0,8'h41,1));
    tv.push_back(mk("rx77",        0,0,0,0,               0,1,8'h77, 0,0,8'h41,F));
    tv.push_back(mk("st_rxdata",   1,1,32'h80000004,0,    0,0,0,     0,0,8'h41,F));
    tv.push_back(mk("rx_head",     1,0,32'h80000004,0,    0,0,0,     'h77,0,8'h41,1));
    do_reset();
    chk("rst.resp", resp_rdata, 0);
    chk("rst.txv", uart_tx_data_in_valid, 0);
    chk("rst.txd", uart_tx_data_in, 0);
    chk("rst.rxr", uart_rx_data_out_ready, 1);
    foreach (tv[i]) begin
      step(tv[i].v, tv[i].we, tv[i].a, tv[i].wd, tv[i].txr, tv[i].rxv, tv[i].rxd, 0);
      chk({tv[i].nm, ".resp"}, resp_rdata, tv[i].resp);
      chk({tv[i].nm, ".txv"}, uart_tx_data_in_valid, tv[i].txv);
      chk({tv[i].nm, ".txd"}, uart_tx_data_in, tv[i].txd);
      chk({tv[i].nm, ".rxr"}, uart_rx_data_out_ready, tv[i].rxr);
    end
    // counters: clear, 100 cycles with retire on alternate cycles
    step(1, 1, 32'h80000018, 0, 0, 0, 0, 0);
    for (int k = 0; k < 100; k++) step(0, 0, 0, 0, 0, 0, 0, k % 2 == 0);
    load(32'h80000010);
    chk("cyc100", resp_rdata, 100);
    load(32'h80000014);
    chk("instr50", resp_rdata, 50);
    step(1, 1, 32'h80000018, 0, 0, 0, 0, 1);
    load(32'h80000010);
    chk("cyc_clr", resp_rdata, 0);
    load(32'h80000014);
    chk("instr_clr", resp_rdata, 0);
    // TX store while full and handshaking: slot frees, store still dropped
    step(1, 1, 32'h80000008, 'hA1, 0, 0, 0, 0);
    step(1, 1, 32'h80000008, 'hA2, 1, 0, 0, 0);
    chk("txrace.txv", uart_tx_data_in_valid, 0);
    chk("txrace.txd", uart_tx_data_in, 'hA1);
`ifdef MMIO_RX_FIFO_EN
    do_reset();
    for (int k = 0; k < 9; k++) begin
      idle(1, 8'(8'h10 + k));
      chk($sformatf("fill%0d.rxr", k), uart_rx_data_out_ready, k < 7);
    end
    load(32'h80000004);
    chk("fpop0", resp_rdata, 'h10);
    chk("fpop0.rxr", uart_rx_data_out_ready, 1);
    load(32'h80000004, 1, 8'h18);
    chk("fpoppush", resp_rdata, 'h11);
    chk("fpoppush.rxr", uart_rx_data_out_ready, 1);
    idle(1, 8'h19);
    chk("frefill.rxr", uart_rx_data_out_ready, 0);
    for (int k = 0; k < 9; k++) begin
      load(32'h80000004);
      chk($sformatf("fdrain%0d", k), resp_rdata, k < 8 ? 32'h12 + k : 0);
    end
`endif
    // reset mid-transaction
    do_reset();
    step(1, 1, 32'h80000008, 'h99, 0, 1, 8'hAB, 0);
    load(32'h80000000);
    chk("prerst.st", resp_rdata, 2);
    chk("prerst.txv", uart_tx_data_in_valid, 1);
    rst = 1;
    load(32'h80000010);
    rst = 0;
    chk("midrst.resp", resp_rdata, 0);
    chk("midrst.txv", uart_tx_data_in_valid, 0);
    chk("midrst.rxr", uart_rx_data_out_ready, 1);
    load(32'h80000000);
    chk("postrst.st", resp_rdata, 1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
